countdown_timer_bcd: RTL

- Down-counting MM:SS timer for the digital clock: the borrow-chain counterpart of the up-counting modulo-N carry chain.
- Operator loads a BCD start value, starts and pauses the countdown; decrements once per 1 Hz enable pulse.
- Flags expiry to the alarm/buzzer logic.
- Sits beside the timekeeping counters; consumes the same 1 Hz enable and drives the display mux.

---
 rtl/countdown_timer_bcd_pkg.sv | 15 +
 rtl/countdown_timer_bcd_digit.sv | 28 ++
 rtl/countdown_timer_bcd.sv | 102 ++++++++++
 3 files changed

// File: rtl/countdown_timer_bcd_pkg.sv
// rtl/countdown_timer_bcd_pkg.sv - shared state encoding and digit limits for the MM:SS countdown timer
package countdown_timer_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam int BCD_MAX_ONES     = 9;
   localparam int SEC_TENS_MAX_DEF = 5;
   localparam int MIN_TENS_MAX_DEF = 9;

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// rtl/countdown_timer_bcd_digit.sv - one BCD down-counting digit with clamped load and borrow output
module bcd_down_digit #(
   parameter int MAX = 9
) (
   input  logic       Clk,
   input  logic       RST,
   input  logic       dec_en,
   input  logic       load,
   input  logic [3:0] load_d,
   output logic [3:0] q,
   output logic       borrow_out
);

   localparam logic [3:0] MAX_D = 4'(MAX);

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         q <= 4'd0;
      end else if (load) begin
         q <= (load_d > MAX_D) ? MAX_D : load_d;
      end else if (dec_en) begin
         q <= (q == 4'd0) ? MAX_D : q - 4'd1;
      end
   end

   assign borrow_out = dec_en && (q == 4'd0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - MM:SS BCD countdown timer: borrow-chained digits plus run/pause/expire FSM
module countdown_timer_bcd
   import countdown_timer_bcd_pkg::*;
#(
   parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
   parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
   input  logic        Clk,
   input  logic        RST,
   input  logic        tick,
   input  logic        start,
   input  logic        pause,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [3:0]  min_t,
   output logic [3:0]  min_o,
   output logic [3:0]  sec_t,
   output logic [3:0]  sec_o,
   output logic        running,
   output logic        done,
   output logic        expired
);

   state_t state;
   logic   load_acc;
   logic   tick_dec;
   logic   borrow_so, borrow_st, borrow_mo, borrow_mt;
   logic   value_nz;
   logic   at_one;

   assign load_acc = load && (state != ST_RUN);
   assign tick_dec = (state == ST_RUN) && tick && !pause;
   assign value_nz = |{min_t, min_o, sec_t, sec_o};
   assign at_one   = ({min_t, min_o, sec_t} == 12'h000) && (sec_o == 4'd1);

   bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_sec_o (
      .Clk(Clk), .RST(RST), .dec_en(tick_dec), .load(load_acc),
      .load_d(load_val[3:0]), .q(sec_o), .borrow_out(borrow_so)
   );

   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_t (
      .Clk(Clk), .RST(RST), .dec_en(borrow_so), .load(load_acc),
      .load_d(load_val[7:4]), .q(sec_t), .borrow_out(borrow_st)
   );

   bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_min_o (
      .Clk(Clk), .RST(RST), .dec_en(borrow_st), .load(load_acc),
      .load_d(load_val[11:8]), .q(min_o), .borrow_out(borrow_mo)
   );

   bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_t (
      .Clk(Clk), .RST(RST), .dec_en(borrow_mo), .load(load_acc),
      .load_d(load_val[15:12]), .q(min_t), .borrow_out(borrow_mt)
   );

   // A borrow out of min_t means RUN was entered at 00:00, which the FSM prevents; treat it as expiry anyway.
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         expired <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load_acc) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            expired <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && value_nz) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (pause) begin
                     state   <= ST_PAUSED;
                     running <= 1'b0;
                  end else if (tick_dec && (at_one || borrow_mt)) begin
                     state   <= ST_EXPIRED;
                     running <= 1'b0;
                     expired <= 1'b1;
                     done    <= 1'b1;
                  end
               end
               ST_PAUSED: begin
                  if (start && !pause) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               default: begin
                  state <= ST_EXPIRED;
               end
            endcase
         end
      end
   end

endmodule
